// File: rtl/modulo_controle_jogo.sv
// Turn sequencer for the naval-battle game: arms the position matrix, then runs shoot/evaluate/show turns.
// Latency: confirm edge t -> sel_coord t+1 -> at_we/counters t+2 -> colour t+3..t+2+HOLD_CYC.
// Backpressure: confirm edges arriving while a turn is being evaluated or shown are dropped, never queued.
module modulo_controle_jogo #(
    parameter int MAX_SHOTS = 20,
    parameter int SHOT_W    = 5,
    parameter int HOLD_CYC  = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              btn_confirm,
    input  logic [5:0]        at_in,
    input  logic [5:0]        ship_total,
    input  logic              po_cell,
    input  logic              at_cell,
    output logic [5:0]        sel_coord,
    output logic              po_load,
    output logic              at_clear,
    output logic              at_we,
    output logic [1:0]        phase,
    output logic              rgb_r,
    output logic              rgb_g,
    output logic [SHOT_W-1:0] shots_left,
    output logic [5:0]        hits,
    output logic              game_over,
    output logic              win
);

    localparam int                CNT_W      = $clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(HOLD_CYC);
    localparam logic [SHOT_W-1:0] SHOTS_INIT = SHOT_W'(MAX_SHOTS);

    typedef enum logic [2:0] {
        S_SETUP,
        S_LOAD,
        S_ATTACK,
        S_EVAL,
        S_SHOW,
        S_REJECT,
        S_OVER
    } state_t;

    state_t             state, state_d;
    logic               btn_q;
    logic               cfm;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_d;
    logic               hit_q, hit_d;
    logic [5:0]         ship_q, ship_d;
    logic [5:0]         sel_d;
    logic [SHOT_W-1:0]  shots_d;
    logic [5:0]         hits_d;
    logic               win_d;
    logic               rgb_r_d, rgb_g_d;
    logic               po_load_d, at_clear_d, at_we_d;
    logic               game_over_d;
    logic [1:0]         phase_d;
    logic               coord_bad;

    assign cfm       = btn_confirm & ~btn_q;
    assign coord_bad = (sel_coord[5:3] > 3'd4) | (sel_coord[2:0] > 3'd6);

    always_comb begin
        state_d    = state;
        hold_cnt_d = hold_cnt;
        hit_d      = hit_q;
        ship_d     = ship_q;
        sel_d      = sel_coord;
        shots_d    = shots_left;
        hits_d     = hits;
        win_d      = win;
        rgb_r_d    = 1'b0;
        rgb_g_d    = 1'b0;
        at_we_d    = 1'b0;

        case (state)
            S_SETUP: begin
                if (cfm) state_d = S_LOAD;
            end
            S_LOAD: begin
                hits_d  = '0;
                shots_d = SHOTS_INIT;
                ship_d  = ship_total;
                win_d   = 1'b0;
                if (ship_total == 6'd0) begin
                    state_d = S_OVER;
                    win_d   = 1'b1;
                end else begin
                    state_d = S_ATTACK;
                end
            end
            S_ATTACK: begin
                if (cfm) begin
                    sel_d   = at_in;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                hold_cnt_d = '0;
                if (coord_bad | at_cell) begin
                    state_d = S_REJECT;
                end else begin
                    at_we_d = 1'b1;
                    shots_d = shots_left - 1'b1;
                    hits_d  = hits + {5'd0, po_cell};
                    hit_d   = po_cell;
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (hold_cnt != HOLD_LAST) begin
                    rgb_g_d    = hit_q;
                    rgb_r_d    = ~hit_q;
                    hold_cnt_d = hold_cnt + 1'b1;
                end else if (hits == ship_q) begin
                    // a winning last shot outranks running out of shots
                    state_d = S_OVER;
                    win_d   = 1'b1;
                end else if (shots_left == '0) begin
                    state_d = S_OVER;
                    win_d   = 1'b0;
                end else begin
                    state_d = S_ATTACK;
                end
            end
            S_REJECT: begin
                if (hold_cnt != HOLD_LAST) begin
                    rgb_g_d    = 1'b1;
                    rgb_r_d    = 1'b1;
                    hold_cnt_d = hold_cnt + 1'b1;
                end else begin
                    state_d = S_ATTACK;
                end
            end
            S_OVER: begin
                if (cfm) begin
                    state_d = S_SETUP;
                    win_d   = 1'b0;
                end
            end
            default: state_d = S_SETUP;
        endcase

        // outputs are registered from the next state so they line up with it
        if (state_d == S_OVER) begin
            rgb_g_d = win_d;
            rgb_r_d = ~win_d;
        end
        po_load_d   = (state_d == S_LOAD);
        at_clear_d  = (state_d == S_LOAD);
        game_over_d = (state_d == S_OVER);
        case (state_d)
            S_SETUP: phase_d = 2'b00;
            S_OVER:  phase_d = 2'b10;
            default: phase_d = 2'b01;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state      <= S_SETUP;
            btn_q      <= 1'b1;
            hold_cnt   <= '0;
            hit_q      <= 1'b0;
            ship_q     <= '0;
            sel_coord  <= '0;
            shots_left <= SHOTS_INIT;
            hits       <= '0;
            win        <= 1'b0;
            rgb_r      <= 1'b0;
            rgb_g      <= 1'b0;
            po_load    <= 1'b0;
            at_clear   <= 1'b0;
            at_we      <= 1'b0;
            game_over  <= 1'b0;
            phase      <= 2'b00;
        end else begin
            state      <= state_d;
            btn_q      <= btn_confirm;
            hold_cnt   <= hold_cnt_d;
            hit_q      <= hit_d;
            ship_q     <= ship_d;
            sel_coord  <= sel_d;
            shots_left <= shots_d;
            hits       <= hits_d;
            win        <= win_d;
            rgb_r      <= rgb_r_d;
            rgb_g      <= rgb_g_d;
            po_load    <= po_load_d;
            at_clear   <= at_clear_d;
            at_we      <= at_we_d;
            game_over  <= game_over_d;
            phase      <= phase_d;
        end
    end

endmodule

// File: tb/tb_modulo_controle_jogo.sv
// Bench for modulo_controle_jogo: turn-level game model scheduling expected outputs per cycle,
// checked every cycle, plus literal end-of-step expectations.
module tb_modulo_controle_jogo;

    localparam int MAX = 20;
    localparam int H   = 4;

    typedef struct packed {
        logic [1:0] phase;
        logic [5:0] sel;
        logic [4:0] shots;
        logic [5:0] hits;
        logic       go;
        logic       win;
        logic       r;
        logic       g;
        logic       po_load;
        logic       at_clear;
        logic       at_we;
    } snap_t;

    typedef enum {M_SETUP, M_ATTACK, M_OVER} mstate_t;

    logic       clk, clr, btn;
    logic [5:0] at_in, ship_total;
    logic       po_cell, at_cell;
    logic [5:0] sel_coord;
    logic       po_load, at_clear, at_we;
    logic [1:0] phase;
    logic       rgb_r, rgb_g;
    logic [4:0] shots_left;
    logic [5:0] hits;
    logic       game_over, win;

    logic [34:0] ship_map, env_at, mfired;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          busy_until = 0;
    bit          checking = 0;
    snap_t       tl [int];
    snap_t       cur, mlast, rst_s;
    mstate_t     mst;
    logic [5:0]  mship;
    int          cnt_we, cnt_pl, cnt_ac, cnt_g, cnt_r, cnt_rg;

    modulo_controle_jogo #(.MAX_SHOTS(MAX), .SHOT_W(5), .HOLD_CYC(H)) dut (
        .clk(clk), .clr(clr), .btn_confirm(btn), .at_in(at_in), .ship_total(ship_total),
        .po_cell(po_cell), .at_cell(at_cell), .sel_coord(sel_coord), .po_load(po_load),
        .at_clear(at_clear), .at_we(at_we), .phase(phase), .rgb_r(rgb_r), .rgb_g(rgb_g),
        .shots_left(shots_left), .hits(hits), .game_over(game_over), .win(win)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic cvalid(input logic [5:0] c);
        return (c[5:3] <= 3'd4) && (c[2:0] <= 3'd6);
    endfunction

    function automatic int cidx(input logic [5:0] c);
        return int'(c[5:3]) * 7 + int'(c[2:0]);
    endfunction

    // environment: position and attack matrices addressed by sel_coord
    assign po_cell = cvalid(sel_coord) ? ship_map[cidx(sel_coord)] : 1'b0;
    assign at_cell = cvalid(sel_coord) ? env_at[cidx(sel_coord)] : 1'b0;

    always @(posedge clk) begin
        if (at_clear) env_at <= '0;
        else if (at_we && cvalid(sel_coord)) env_at[cidx(sel_coord)] <= 1'b1;
    end

    task automatic put(input int c, input snap_t s);
        tl[c] = s;
        mlast = s;
    endtask

    // turn-level model: a confirm raised during cycle t is resolved into a timeline of outputs
    task automatic model_press(input int t, input logic [5:0] c);
        snap_t s;
        logic  ok, hit;
        int    i;
        if (t < busy_until) return;
        s = mlast;
        s.po_load = 1'b0; s.at_clear = 1'b0; s.at_we = 1'b0;
        case (mst)
            M_SETUP: begin
                s.phase = 2'b01; s.po_load = 1'b1; s.at_clear = 1'b1;
                put(t + 1, s);
                s.po_load = 1'b0; s.at_clear = 1'b0;
                s.hits = 6'd0; s.shots = 5'(MAX);
                mfired = '0;
                mship = ship_total;
                if (mship == 6'd0) begin
                    s.phase = 2'b10; s.go = 1'b1; s.win = 1'b1; s.g = 1'b1; s.r = 1'b0;
                    mst = M_OVER;
                end else begin
                    mst = M_ATTACK;
                end
                put(t + 2, s);
                busy_until = t + 2;
            end
            M_ATTACK: begin
                s.sel = c;
                put(t + 1, s);
                i   = cvalid(c) ? cidx(c) : 0;
                ok  = cvalid(c) && !mfired[i];
                hit = ok && ship_map[i];
                if (ok) begin
                    s.at_we = 1'b1;
                    s.shots = s.shots - 5'd1;
                    s.hits  = s.hits + {5'd0, hit};
                    mfired[i] = 1'b1;
                    put(t + 2, s);
                    s.at_we = 1'b0; s.g = hit; s.r = !hit;
                end else begin
                    put(t + 2, s);
                    s.g = 1'b1; s.r = 1'b1;
                end
                put(t + 3, s);
                s.g = 1'b0; s.r = 1'b0;
                if (ok && s.hits == mship) begin
                    s.phase = 2'b10; s.go = 1'b1; s.win = 1'b1; s.g = 1'b1;
                    mst = M_OVER;
                end else if (ok && s.shots == 5'd0) begin
                    s.phase = 2'b10; s.go = 1'b1; s.win = 1'b0; s.r = 1'b1;
                    mst = M_OVER;
                end
                put(t + 3 + H, s);
                busy_until = t + 3 + H;
            end
            default: begin
                s.phase = 2'b00; s.go = 1'b0; s.win = 1'b0; s.r = 1'b0; s.g = 1'b0;
                put(t + 1, s);
                mst = M_SETUP;
                busy_until = t + 1;
            end
        endcase
    endtask

    task automatic model_reset(input int t);
        int k;
        while (tl.last(k) && k > t) tl.delete(k);
        put(t + 1, rst_s);
        mst = M_SETUP;
        busy_until = t + 1;
    endtask

    always @(negedge clk) begin
        snap_t act;
        if (checking) begin
            if (tl.exists(cyc)) begin
                cur = tl[cyc];
                tl.delete(cyc);
            end else begin
                cur.po_load = 1'b0; cur.at_clear = 1'b0; cur.at_we = 1'b0;
            end
            act.phase = phase;      act.sel = sel_coord; act.shots = shots_left;
            act.hits = hits;        act.go = game_over;  act.win = win;
            act.r = rgb_r;          act.g = rgb_g;       act.po_load = po_load;
            act.at_clear = at_clear; act.at_we = at_we;
            n_cmp++;
            if (act !== cur) begin
                n_bad++;
                $display("FAIL cycle %0d outputs: got %p required %p", cyc, act, cur);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic clear_counts();
        cnt_we = 0; cnt_pl = 0; cnt_ac = 0; cnt_g = 0; cnt_r = 0; cnt_rg = 0;
    endtask

    task automatic step();
        @(negedge clk);
        cnt_we += int'(at_we);
        cnt_pl += int'(po_load);
        cnt_ac += int'(at_clear);
        cnt_g  += int'(rgb_g & ~rgb_r & ~game_over);
        cnt_r  += int'(rgb_r & ~rgb_g & ~game_over);
        cnt_rg += int'(rgb_r & rgb_g);
    endtask

    task automatic press(input logic [5:0] c);
        at_in = c;
        btn   = 1'b1;
        model_press(cyc, c);
        step();
        step();
        btn = 1'b0;
        step();
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (cyc < busy_until && guard < 100) begin
            step();
            guard++;
        end
        chk("idle_timeout", int'(cyc >= busy_until), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete in time");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr = 1'b0; btn = 1'b1; at_in = '0; ship_total = '0;
        ship_map = '0; env_at = '0; mfired = '0; mship = '0;
        rst_s = '0;
        rst_s.shots = 5'(MAX);
        cur = rst_s; mlast = rst_s; mst = M_SETUP;
        clear_counts();
        repeat (2) @(negedge clk);
        checking = 1'b1;
        clr = 1'b1;

        // button held through reset: releasing it must not start a game
        repeat (3) step();
        btn = 1'b0;
        repeat (3) step();
        chk("reset_phase", int'(phase), 0);
        chk("reset_shots", int'(shots_left), 20);
        chk("reset_strobes", int'({po_load, at_clear, at_we}), 0);

        // game 1: ships at (2,3) and (4,6)
        ship_map = '0;
        ship_map[17] = 1'b1;
        ship_map[34] = 1'b1;
        ship_total = 6'd2;
        clear_counts();
        press(6'b000_000);
        wait_idle();
        chk("load_po_load_pulses", cnt_pl, 1);
        chk("load_at_clear_pulses", cnt_ac, 1);
        chk("load_phase", int'(phase), 1);
        chk("load_hits", int'(hits), 0);

        clear_counts();
        press(6'b010_011);
        wait_idle();
        chk("hit1_sel", int'(sel_coord), 6'b010011);
        chk("hit1_we_pulses", cnt_we, 1);
        chk("hit1_hits", int'(hits), 1);
        chk("hit1_shots", int'(shots_left), 19);
        chk("hit1_green_cycles", cnt_g, 4);

        clear_counts();
        press(6'b101_000);
        wait_idle();
        chk("rej_col_we", cnt_we, 0);
        chk("rej_col_yellow", cnt_rg, 4);
        chk("rej_col_shots", int'(shots_left), 19);

        clear_counts();
        press(6'b010_011);
        wait_idle();
        chk("rej_rep_we", cnt_we, 0);
        chk("rej_rep_yellow", cnt_rg, 4);
        chk("rej_rep_hits", int'(hits), 1);

        clear_counts();
        press(6'b000_000);
        wait_idle();
        chk("miss_red_cycles", cnt_r, 4);
        chk("miss_shots", int'(shots_left), 18);

        // winning shot, with a press landing during the colour hold
        clear_counts();
        press(6'b100_110);
        press(6'b000_001);
        wait_idle();
        chk("win_we_pulses", cnt_we, 1);
        chk("win_game_over", int'(game_over), 1);
        chk("win_win", int'(win), 1);
        chk("win_rgb_g", int'(rgb_g), 1);
        chk("win_hits", int'(hits), 2);
        chk("win_shots", int'(shots_left), 17);

        press(6'b000_000);
        wait_idle();
        chk("over_to_setup", int'(phase), 0);

        // game 2: a single ship at (0,0), fire all 20 shots elsewhere
        ship_map = '0;
        ship_map[0] = 1'b1;
        ship_total = 6'd1;
        press(6'b000_000);
        wait_idle();
        for (int i = 1; i <= 20; i++) begin
            press({3'(i / 7), 3'(i % 7)});
            wait_idle();
        end
        chk("lose_shots", int'(shots_left), 0);
        chk("lose_game_over", int'(game_over), 1);
        chk("lose_win", int'(win), 0);
        chk("lose_rgb_r", int'(rgb_r), 1);
        press(6'b000_000);
        wait_idle();
        chk("lose_to_setup", int'(phase), 0);

        // reset in the middle of a shot's colour hold
        press(6'b000_000);
        wait_idle();
        press(6'b000_000);
        clr = 1'b0;
        model_reset(cyc);
        step();
        clr = 1'b1;
        step();
        chk("midshow_phase", int'(phase), 0);
        chk("midshow_shots", int'(shots_left), 20);
        chk("midshow_hits", int'(hits), 0);
        chk("midshow_rgb", int'({rgb_r, rgb_g}), 0);
        chk("midshow_strobes", int'({po_load, at_clear, at_we}), 0);

        // empty preset ends the game immediately as a win
        ship_total = 6'd0;
        press(6'b000_000);
        wait_idle();
        chk("empty_game_over", int'(game_over), 1);
        chk("empty_win", int'(win), 1);
        press(6'b000_000);
        wait_idle();
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
